// File: rtl/mole_pkg.sv
// Shared types and constants for the whack-a-mole game core.
package mole_pkg;

  typedef enum logic [1:0] {IDLE, PLAY, OVER} state_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Feedback taps 16,14,13,11 mapped onto bits 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) n = n + 5'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/mole_lfsr.sv
// 16-bit Fibonacci LFSR, shift-left form; exposes its low OUT_W bits.
module mole_lfsr
  import mole_pkg::*;
#(
  parameter int OUT_W = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             en_i,
  output logic [OUT_W-1:0] q_o
);

  logic [15:0] lfsr_q;
  logic        fb_d;

  assign fb_d = ^(lfsr_q & LFSR_TAPS);
  assign q_o  = lfsr_q[OUT_W-1:0];

  always_ff @(posedge CLK) begin
    if (RESET)     lfsr_q <= LFSR_SEED;
    else if (en_i) lfsr_q <= {lfsr_q[14:0], fb_d};
  end

endmodule

// File: rtl/mole_game_core.sv
// Whack-a-mole game engine: tick prescaler, mole pattern generation, press
// detection, saturating score and IDLE/PLAY/OVER sequencing.
module mole_game_core
  import mole_pkg::*;
#(
  parameter int N_HOLES    = 8,
  parameter int SCORE_W    = 8,
  parameter int GAME_TICKS = 100,
  parameter int TICK_DIV   = 50000,
  parameter int MOLE_TICKS = 5,
  parameter int PENALTY    = 0
) (
  input  logic                            CLK,
  input  logic                            RESET,
  input  logic                            start,
  input  logic [N_HOLES-1:0]              keypad,
  output logic [N_HOLES-1:0]              mole,
  output logic [SCORE_W-1:0]              score,
  output logic [$clog2(GAME_TICKS+1)-1:0] timer,
  output logic                            game_over,
  output logic                            hit_pulse
);

  localparam int TW = $clog2(GAME_TICKS+1);
  localparam int PW = $clog2(TICK_DIV);
  localparam int MW = (MOLE_TICKS > 1) ? $clog2(MOLE_TICKS) : 1;
  localparam int SW = SCORE_W + 5;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [MW-1:0] MCNT_MAX  = MW'(MOLE_TICKS - 1);
  localparam logic [TW-1:0] TIMER_INIT = TW'(GAME_TICKS);
  localparam logic signed [SW-1:0] SCORE_MAX = SW'(2**SCORE_W - 1);

  state_e               state_q;
  logic [N_HOLES-1:0]   mole_q, keypad_q;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [TW-1:0]        timer_q;
  logic [PW-1:0]        presc_q;
  logic [MW-1:0]        mcnt_q;
  logic                 game_over_q, hit_pulse_q;

  logic [N_HOLES-1:0]   lfsr_bits, pat_d, press_d, hits_d, miss_d;
  logic                 tick_d;
  logic [4:0]           pc_hit_d, pc_miss_d;
  logic signed [SW-1:0] sum_d, pen_d;

  mole_lfsr #(.OUT_W(N_HOLES)) u_lfsr (
    .CLK  (CLK),
    .RESET(RESET),
    .en_i (1'b1),
    .q_o  (lfsr_bits)
  );

  always_comb begin
    pat_d     = (lfsr_bits == '0) ? N_HOLES'(1) : lfsr_bits;
    press_d   = keypad & ~keypad_q;
    hits_d    = press_d & mole_q;
    miss_d    = press_d & ~mole_q;
    tick_d    = (state_q != IDLE) && (presc_q == PRESC_MAX);
    pc_hit_d  = popcount16(16'(hits_d));
    pc_miss_d = popcount16(16'(miss_d));
    pen_d     = (PENALTY != 0) ? $signed(SW'(pc_miss_d)) : '0;
    sum_d     = $signed(SW'(score_q)) + $signed(SW'(pc_hit_d)) - pen_d;
    if (sum_d < 0)              score_d = '0;
    else if (sum_d > SCORE_MAX) score_d = '1;
    else                        score_d = sum_d[SCORE_W-1:0];
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= IDLE;
      mole_q      <= '0;
      keypad_q    <= '0;
      score_q     <= '0;
      timer_q     <= TIMER_INIT;
      presc_q     <= '0;
      mcnt_q      <= '0;
      game_over_q <= 1'b0;
      hit_pulse_q <= 1'b0;
    end else begin
      keypad_q    <= keypad;
      hit_pulse_q <= 1'b0;
      case (state_q)
        PLAY: begin
          score_q     <= score_d;
          hit_pulse_q <= (hits_d != '0);
          presc_q     <= tick_d ? '0 : presc_q + PW'(1);
          mole_q      <= mole_q & ~hits_d;
          if (tick_d) begin
            timer_q <= timer_q - TW'(1);
            if (timer_q == TW'(1)) begin
              // Final tick: hits above are still scored, then flash begins lit
              state_q     <= OVER;
              game_over_q <= 1'b1;
              mole_q      <= '1;
            end else if (mcnt_q == MCNT_MAX) begin
              mcnt_q <= '0;
              mole_q <= pat_d;
            end else begin
              mcnt_q <= mcnt_q + MW'(1);
            end
          end
        end
        default: begin
          if (start) begin
            state_q     <= PLAY;
            score_q     <= '0;
            timer_q     <= TIMER_INIT;
            presc_q     <= '0;
            mcnt_q      <= '0;
            mole_q      <= pat_d;
            game_over_q <= 1'b0;
          end else if (state_q == OVER) begin
            presc_q <= tick_d ? '0 : presc_q + PW'(1);
            if (tick_d) mole_q <= ~mole_q;
          end
        end
      endcase
    end
  end

  assign mole      = mole_q;
  assign score     = score_q;
  assign timer     = timer_q;
  assign game_over = game_over_q;
  assign hit_pulse = hit_pulse_q;

endmodule

// File: tb/tb_mole_game_core.sv
// Randomized bench: two cores (PENALTY 0 and 1) share stimulus and are
// compared every cycle against a game-rule reference model.
module tb_mole_game_core;

  localparam int NH = 8, SWD = 4, GT = 5, TD = 4, MT = 1;
  localparam int SMAX = 15;
  localparam int NCYC = 3000;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       start = 1'b0;
  logic [7:0] keypad = '0;

  logic [7:0] d_mole [2];
  logic [3:0] d_score [2];
  logic [2:0] d_timer [2];
  logic       d_go [2];
  logic       d_hp [2];

  always #5 CLK = ~CLK;

  mole_game_core #(.N_HOLES(NH), .SCORE_W(SWD), .GAME_TICKS(GT), .TICK_DIV(TD),
                   .MOLE_TICKS(MT), .PENALTY(0)) dut0 (
    .CLK(CLK), .RESET(RESET), .start(start), .keypad(keypad),
    .mole(d_mole[0]), .score(d_score[0]), .timer(d_timer[0]),
    .game_over(d_go[0]), .hit_pulse(d_hp[0]));

  mole_game_core #(.N_HOLES(NH), .SCORE_W(SWD), .GAME_TICKS(GT), .TICK_DIV(TD),
                   .MOLE_TICKS(MT), .PENALTY(1)) dut1 (
    .CLK(CLK), .RESET(RESET), .start(start), .keypad(keypad),
    .mole(d_mole[1]), .score(d_score[1]), .timer(d_timer[1]),
    .game_over(d_go[1]), .hit_pulse(d_hp[1]));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h @%0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 = waiting, 1 = game running, 2 = game finished
  int         m_mode [2];
  int         m_sc [2], m_tm [2], m_cyc [2], m_ticks [2];
  logic [7:0] m_ml [2];
  bit         m_hp [2];
  logic [7:0] m_kq;
  logic [15:0] m_lf;

  always @(posedge CLK) begin
    logic [7:0] press, hits, pat;
    int v;
    press = keypad & ~m_kq;
    pat   = (m_lf[7:0] == 8'h00) ? 8'h01 : m_lf[7:0];
    for (int p = 0; p < 2; p++) begin
      if (RESET) begin
        m_mode[p] = 0; m_sc[p] = 0; m_tm[p] = GT; m_cyc[p] = 0;
        m_ticks[p] = 0; m_ml[p] = 8'h00; m_hp[p] = 0;
      end else if (m_mode[p] == 1) begin
        hits = press & m_ml[p];
        v = m_sc[p] + $countones(hits) - (p == 1 ? $countones(press & ~m_ml[p]) : 0);
        m_sc[p] = (v < 0) ? 0 : (v > SMAX ? SMAX : v);
        m_hp[p] = (hits != 0);
        m_ml[p] = m_ml[p] & ~hits;
        m_cyc[p]++;
        if (m_cyc[p] == TD) begin
          m_cyc[p] = 0;
          m_tm[p]--;
          if (m_tm[p] == 0) begin
            m_mode[p] = 2; m_ml[p] = 8'hFF;
          end else begin
            m_ticks[p]++;
            if (m_ticks[p] == MT) begin m_ticks[p] = 0; m_ml[p] = pat; end
          end
        end
      end else if (start) begin
        m_mode[p] = 1; m_sc[p] = 0; m_tm[p] = GT; m_cyc[p] = 0;
        m_ticks[p] = 0; m_ml[p] = pat; m_hp[p] = 0;
      end else begin
        m_hp[p] = 0;
        if (m_mode[p] == 2) begin
          m_cyc[p] = (m_cyc[p] + 1) % TD;
          if (m_cyc[p] == 0) m_ml[p] = ~m_ml[p];
        end
      end
    end
    m_kq = RESET ? 8'h00 : keypad;
    m_lf = RESET ? 16'hACE1 : {m_lf[14:0], m_lf[15] ^ m_lf[13] ^ m_lf[12] ^ m_lf[10]};
  end

  initial begin
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge CLK);
      if (cyc >= 1) begin
        for (int p = 0; p < 2; p++) begin
          chk($sformatf("mole%0d", p),  32'(d_mole[p]),  32'(m_ml[p]));
          chk($sformatf("score%0d", p), 32'(d_score[p]), 32'(m_sc[p]));
          chk($sformatf("timer%0d", p), 32'(d_timer[p]), 32'(m_tm[p]));
          chk($sformatf("over%0d", p),  32'(d_go[p]),    32'(m_mode[p] == 2));
          chk($sformatf("hit%0d", p),   32'(d_hp[p]),    32'(m_hp[p]));
        end
      end
      RESET = (cyc < 3) || ($urandom_range(0, 399) == 0);
      if (m_mode[0] == 1) start = ($urandom_range(0, 7) == 0);
      else                start = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 5))
        0, 1:    keypad = 8'h00;
        2, 3:    keypad = m_ml[0] & 8'($urandom);
        4:       keypad = keypad;
        default: keypad = 8'($urandom);
      endcase
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
